// File: rtl/stream_mem_writer_if.sv
// Stream-in / memory-out signal bundle for stream_mem_writer.
// slave is the writer's view; master is the producer/memory side.
interface stream_mem_writer_if #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 10
);
    logic [dataWidth-1:0] din;
    logic                 dinValid;
    logic                 dinReady;
    logic                 memWrEn;
    logic [addrWidth-1:0] memAddr;
    logic [dataWidth-1:0] memData;

    modport slave (
        input  din, dinValid,
        output dinReady, memWrEn, memAddr, memData
    );

    modport master (
        output din, dinValid,
        input  dinReady, memWrEn, memAddr, memData
    );
endinterface

// File: rtl/stream_mem_writer.sv
// Drains a valid/ready stream into a scratchpad at a strided address sequence.
// IDLE -> RUN -> DONE; dinReady is a Moore decode of the state register.
module stream_mem_writer #(
    parameter int dataWidth  = 32,
    parameter int addrWidth  = 10,
    parameter int countWidth = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addrWidth-1:0]  baseAddr,
    input  logic [addrWidth-1:0]  stride,
    input  logic [countWidth-1:0] count,
    stream_mem_writer_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic [countWidth-1:0] wordsWritten
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [addrWidth-1:0]  cur_addr;
        logic [addrWidth-1:0]  stride;
        logic [countWidth-1:0] remaining;
    } xfer_t;

    state_t                state, state_nxt;
    xfer_t                 xfer;
    logic                  wr_en;
    logic [addrWidth-1:0]  wr_addr;
    logic [dataWidth-1:0]  wr_data;
    logic [countWidth-1:0] words_q;
    logic                  take_start, accept;

    assign take_start = (state == IDLE) && start;
    assign accept     = (state == RUN) && bus.dinValid;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (count != '0) ? RUN : DONE;
            RUN:  if (accept && xfer.remaining == countWidth'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer parameters are only loaded in IDLE, so mid-run input changes are invisible.
    always_ff @(posedge clock) begin
        if (reset) begin
            xfer    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            words_q <= '0;
        end else begin
            wr_en <= accept;
            if (take_start) begin
                xfer.cur_addr  <= baseAddr;
                xfer.stride    <= stride;
                xfer.remaining <= count;
                words_q        <= '0;
            end
            if (accept) begin
                wr_addr        <= xfer.cur_addr;
                wr_data        <= bus.din;
                xfer.cur_addr  <= xfer.cur_addr + xfer.stride;
                xfer.remaining <= xfer.remaining - countWidth'(1);
                words_q        <= words_q + countWidth'(1);
            end
        end
    end

    assign bus.dinReady = (state == RUN);
    assign bus.memWrEn  = wr_en;
    assign bus.memAddr  = wr_addr;
    assign bus.memData  = wr_data;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign wordsWritten = words_q;
endmodule

// File: tb/tb_stream_mem_writer.sv
// Directed bench for stream_mem_writer: basic, bubbles, wrap, zero length,
// ignored start and mid-transfer reset, all with hand-computed expectations.
module tb_stream_mem_writer;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW-1:0] stride;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic [CW-1:0] wordsWritten;

    int n_checks = 0;
    int n_errors = 0;

    stream_mem_writer_if #(.dataWidth(DW), .addrWidth(AW)) sif ();

    stream_mem_writer #(.dataWidth(DW), .addrWidth(AW), .countWidth(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .baseAddr     (baseAddr),
        .stride       (stride),
        .count        (count),
        .bus          (sif),
        .busy         (busy),
        .done         (done),
        .wordsWritten (wordsWritten)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] c);
        baseAddr = b;
        stride   = s;
        count    = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Offer one beat; a valid beat in RUN must show up as a write right after the edge.
    task automatic beat(input string tag, input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a);
        sif.dinValid = v;
        sif.din      = d;
        tick();
        chk({tag, "_we"}, 32'(sif.memWrEn), 32'(v));
        if (v) begin
            chk({tag, "_addr"}, 32'(sif.memAddr), 32'(a));
            chk({tag, "_data"}, sif.memData, d);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        baseAddr     = '0;
        stride       = '0;
        count        = '0;
        sif.din      = '0;
        sif.dinValid = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(sif.dinReady), 32'd0);
        chk("rst_we",    32'(sif.memWrEn),  32'd0);
        chk("rst_addr",  32'(sif.memAddr),  32'd0);
        chk("rst_data",  sif.memData,       32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_words", 32'(wordsWritten), 32'd0);
        reset = 1'b0;
        tick();

        // Basic back-to-back transfer
        go(10'h010, 10'd1, 16'd4);
        chk("bas_ready", 32'(sif.dinReady), 32'd1);
        chk("bas_busy",  32'(busy),         32'd1);
        beat("bas0", 1'b1, 32'hA0, 10'h010);
        beat("bas1", 1'b1, 32'hA1, 10'h011);
        beat("bas2", 1'b1, 32'hA2, 10'h012);
        chk("bas_nodone", 32'(done), 32'd0);
        beat("bas3", 1'b1, 32'hA3, 10'h013);
        chk("bas_done",   32'(done),         32'd1);
        chk("bas_dready", 32'(sif.dinReady), 32'd0);
        chk("bas_dbusy",  32'(busy),         32'd1);
        sif.dinValid = 1'b0;
        tick();
        chk("bas_idle_busy", 32'(busy),         32'd0);
        chk("bas_idle_done", 32'(done),         32'd0);
        chk("bas_idle_we",   32'(sif.memWrEn),  32'd0);
        chk("bas_words",     32'(wordsWritten), 32'd4);

        // Bubbles in the stream
        go(10'h020, 10'd2, 16'd3);
        beat("bub0", 1'b1, 32'hB0, 10'h020);
        beat("bub1", 1'b0, 32'hFF, 10'h000);
        beat("bub2", 1'b0, 32'hFF, 10'h000);
        beat("bub3", 1'b1, 32'hB1, 10'h022);
        chk("bub_nodone", 32'(done), 32'd0);
        beat("bub4", 1'b0, 32'hFF, 10'h000);
        beat("bub5", 1'b1, 32'hB2, 10'h024);
        chk("bub_done", 32'(done), 32'd1);
        sif.dinValid = 1'b0;
        tick();
        chk("bub_words", 32'(wordsWritten), 32'd3);

        // Address wrap past the top of the scratchpad
        go(10'h3FE, 10'd3, 16'd3);
        beat("wrp0", 1'b1, 32'hC0, 10'h3FE);
        beat("wrp1", 1'b1, 32'hC1, 10'h001);
        beat("wrp2", 1'b1, 32'hC2, 10'h004);
        chk("wrp_done", 32'(done), 32'd1);
        sif.dinValid = 1'b0;
        tick();

        // Zero length, then a start in the DONE cycle that must be ignored
        go(10'h050, 10'd1, 16'd0);
        chk("z_done",  32'(done),         32'd1);
        chk("z_busy",  32'(busy),         32'd1);
        chk("z_ready", 32'(sif.dinReady), 32'd0);
        chk("z_we",    32'(sif.memWrEn),  32'd0);
        chk("z_words", 32'(wordsWritten), 32'd0);
        count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_ign_busy", 32'(busy), 32'd0);
        chk("z_ign_done", 32'(done), 32'd0);
        tick();
        chk("z_ign_idle", 32'(busy), 32'd0);

        // Start during RUN must not disturb the transfer
        go(10'h200, 10'd1, 16'd3);
        beat("ign0", 1'b1, 32'hD0, 10'h200);
        baseAddr = 10'h300;
        stride   = 10'd7;
        count    = 16'd9;
        start    = 1'b1;
        beat("ign1", 1'b1, 32'hD1, 10'h201);
        start    = 1'b0;
        beat("ign2", 1'b1, 32'hD2, 10'h202);
        chk("ign_done", 32'(done), 32'd1);
        tick();
        chk("ign_we",    32'(sif.memWrEn),  32'd0);
        chk("ign_busy",  32'(busy),         32'd0);
        chk("ign_words", 32'(wordsWritten), 32'd3);
        sif.dinValid = 1'b0;
        tick();

        // Reset after 3 of 8 words, with a 4th beat offered at the reset edge
        go(10'h080, 10'd1, 16'd8);
        beat("rm0", 1'b1, 32'hE0, 10'h080);
        beat("rm1", 1'b1, 32'hE1, 10'h081);
        beat("rm2", 1'b1, 32'hE2, 10'h082);
        chk("rm_words3", 32'(wordsWritten), 32'd3);
        reset        = 1'b1;
        sif.din      = 32'hE3;
        sif.dinValid = 1'b1;
        tick();
        chk("rm_we",    32'(sif.memWrEn),  32'd0);
        chk("rm_ready", 32'(sif.dinReady), 32'd0);
        chk("rm_busy",  32'(busy),         32'd0);
        chk("rm_done",  32'(done),         32'd0);
        chk("rm_words", 32'(wordsWritten), 32'd0);
        reset        = 1'b0;
        sif.dinValid = 1'b0;
        tick();
        chk("rm_nodone", 32'(done), 32'd0);
        go(10'h180, 10'd4, 16'd2);
        beat("rn0", 1'b1, 32'hF0, 10'h180);
        beat("rn1", 1'b1, 32'hF1, 10'h184);
        chk("rn_done", 32'(done), 32'd1);
        sif.dinValid = 1'b0;
        tick();
        chk("rn_words", 32'(wordsWritten), 32'd2);
        chk("rn_busy",  32'(busy),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
